// File: rtl/vga_timing_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_receiver
// Purpose  : Rebuilds raster position from sampled hs/vs, measures line and
//            frame lengths, locks to the expected timing, emits de + colour.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       r_in,
  input  logic       g_in,
  input  logic       b_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       sync_err
);

  localparam logic [9:0] C_MAX     = 10'd1023;
  localparam logic [9:0] C_H_TOTAL = 10'(H_TOTAL);
  localparam logic [9:0] C_V_TOTAL = 10'(V_TOTAL);
  localparam logic [9:0] C_HA_LO   = 10'(H_ACT_START);
  localparam logic [9:0] C_HA_HI   = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] C_VA_LO   = 10'(V_ACT_START);
  localparam logic [9:0] C_VA_HI   = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [1:0] C_LOCK    = 2'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic [4:0] r_s1;       // {hs, vs, r, g, b}
  logic [4:0] r_s2;
  logic [1:0] r_s3;       // {hs, vs}
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_vs_pend;
  state_t     r_state;
  logic [1:0] r_good_cnt;
  logic       r_frame_ok;

  logic       w_hs_fall;
  logic       w_vs_fall;
  logic [9:0] w_h_len;
  logic [9:0] w_v_len;
  logic [9:0] w_hpos;
  logic [9:0] w_vpos;
  logic       w_frame_edge;
  logic       w_sat;
  logic       w_line_bad;
  logic       w_frame_bad;
  logic       w_de;
  logic [1:0] w_good_next;

  assign w_hs_fall    = r_s3[1] & ~r_s2[4];
  assign w_vs_fall    = r_s3[0] & ~r_s2[3];
  assign w_h_len      = (r_h_cnt == C_MAX) ? C_MAX : r_h_cnt + 10'd1;
  assign w_v_len      = (r_v_cnt == C_MAX) ? C_MAX : r_v_cnt + 10'd1;
  // A vs edge seen mid-line is held in vs_pend and takes effect at the next line start
  assign w_frame_edge = w_hs_fall & (w_vs_fall | r_vs_pend);
  assign w_hpos       = w_hs_fall ? 10'd0 : w_h_len;
  assign w_vpos       = w_hs_fall ? (w_frame_edge ? 10'd0 : w_v_len) : r_v_cnt;
  assign w_sat        = (w_hpos == C_MAX) | (w_vpos == C_MAX);
  assign w_line_bad   = w_hs_fall & (w_h_len != C_H_TOTAL);
  assign w_frame_bad  = w_frame_edge & (w_v_len != C_V_TOTAL);
  assign w_good_next  = r_good_cnt + 2'd1;
  assign w_de         = locked & (w_hpos >= C_HA_LO) & (w_hpos < C_HA_HI)
                               & (w_vpos >= C_VA_LO) & (w_vpos < C_VA_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1        <= 5'd0;
      r_s2        <= 5'd0;
      r_s3        <= 2'd0;
      r_h_cnt     <= 10'd0;
      r_v_cnt     <= 10'd0;
      r_vs_pend   <= 1'b0;
      h_total     <= 10'd0;
      v_total     <= 10'd0;
      x           <= 10'd0;
      y           <= 10'd0;
      de          <= 1'b0;
      r           <= 1'b0;
      g           <= 1'b0;
      b           <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        r_s1    <= {hs_in, vs_in, r_in, g_in, b_in};
        r_s2    <= r_s1;
        r_s3    <= r_s2[4:3];
        r_h_cnt <= w_hpos;
        r_v_cnt <= w_vpos;
        if (w_hs_fall)
          r_vs_pend <= 1'b0;
        else if (w_vs_fall)
          r_vs_pend <= 1'b1;
        if (w_hs_fall)
          h_total <= w_h_len;
        if (w_frame_edge)
          v_total <= w_v_len;
        x           <= w_hpos;
        y           <= w_vpos;
        de          <= w_de;
        r           <= w_de & r_s2[2];
        g           <= w_de & r_s2[1];
        b           <= w_de & r_s2[0];
        frame_start <= (w_hpos == 10'd0) & (w_vpos == 10'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= 2'd0;
      r_frame_ok <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (pix_ce) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_frame_edge) begin
              r_good_cnt <= 2'd0;
              r_frame_ok <= 1'b1;
              r_state    <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (w_frame_edge) begin
              // The line closed by this edge is the last line of the frame
              r_frame_ok <= 1'b1;
              if (r_frame_ok & ~w_line_bad & ~w_frame_bad & ~w_sat) begin
                if (w_good_next == C_LOCK) begin
                  r_good_cnt <= 2'd0;
                  r_state    <= ST_LOCKED;
                  locked     <= 1'b1;
                end else begin
                  r_good_cnt <= w_good_next;
                end
              end else begin
                r_good_cnt <= 2'd0;
              end
            end else if (w_line_bad | w_sat) begin
              r_frame_ok <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (w_line_bad | w_frame_bad | w_sat) begin
              sync_err <= 1'b1;
              locked   <= 1'b0;
              r_state  <= ST_SEARCH;
            end
          end
          default: begin
            r_state <= ST_SEARCH;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
